// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch-stage constants: default widths, queue depth and the NOP used by IF/ID on a bubble.
`timescale 1ns/1ps
package fetch_prefetch_queue_pkg;

   localparam int unsigned DEF_ADDR_W  = 8;
   localparam int unsigned DEF_INSTR_W = 32;
   localparam int unsigned DEF_DEPTH   = 4;

   // addi x0, x0, 0
   localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [DEF_INSTR_W-1:0] instr;
      logic [DEF_ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head is a combinational read of the storage at the read pointer.
`timescale 1ns/1ps
module fetch_prefetch_queue_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 40
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           head_c,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Flush dominates any push/pop in the same cycle
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_c  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the PC, issues pipelined imem reads under a queue credit check,
// buffers returned words with their PCs and squashes everything on an EX redirect.
`timescale 1ns/1ps
module fetch_prefetch_queue
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned DEPTH   = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam int unsigned ENT_W = INSTR_W + ADDR_W;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic              inflight_q, inflight_d;
   logic              squash_q, squash_d;

   logic              issue_c;
   logic              push_c;
   logic              pop_c;
   logic [OCC_W-1:0]  occ_c;
   logic [CNT_W-1:0]  count;
   logic [ENT_W-1:0]  head_c;

   // Credit counts the outstanding read so a return always has a free slot
   always_comb begin
      occ_c      = OCC_W'(count) + OCC_W'(inflight_q);
      issue_c    = reset & ~redirect_valid & (occ_c < OCC_W'(DEPTH));
      push_c     = inflight_q & ~squash_q & ~redirect_valid;
      out_valid  = (count != '0);
      pop_c      = out_valid & out_ready & ~redirect_valid;
      pc_d       = pc_q;
      tag_d      = tag_q;
      inflight_d = issue_c;
      squash_d   = redirect_valid & inflight_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue_c) begin
         pc_d  = pc_q + ADDR_W'(1);
         tag_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         squash_q   <= squash_d;
      end
   end

   fetch_prefetch_queue_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (redirect_valid),
      .wdata_i ({imem_rdata, tag_q}),
      .head_c  (head_c),
      .count_o (count)
   );

   assign imem_en   = issue_c;
   assign imem_addr = pc_q;
   assign out_instr = head_c[ENT_W-1 -: INSTR_W];
   assign out_pc    = head_c[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue; imem model returns mem[a] = a + 0x100 one cycle after imem_en.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

   logic        clk;
   logic        reset;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;

   int tests;
   int fails;

   fetch_prefetch_queue dut (
      .clk            (clk),
      .reset          (reset),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= 32'h100 + 32'(imem_addr);
   end

   // Leaves the bench 1 ns after the first negedge with reset released (cycle 0)
   task automatic restart(input logic rdy);
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      out_ready = rdy;
      reset     = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
      imem_rdata = 32'h0;
      @(negedge clk); @(negedge clk); #1;
      tests++; if (imem_en !== 1'b0)   begin fails++; $display("FAIL reset_imem_en got %b want 0", imem_en); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
      tests++; if (out_pc !== 8'h0)    begin fails++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
   endtask

   task automatic test_stream;
      restart(1'b1);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         tests++; if (imem_en !== 1'b1) begin fails++; $display("FAIL stream_en c%0d got %b want 1", k, imem_en); end
         tests++; if (imem_addr !== 8'(k)) begin fails++; $display("FAIL stream_addr c%0d got %h want %h", k, imem_addr, 8'(k)); end
         tests++; if (out_valid !== (k >= 2)) begin fails++; $display("FAIL stream_valid c%0d got %b want %b", k, out_valid, (k >= 2)); end
         if (k >= 2) begin
            tests++; if (out_pc !== 8'(k - 2)) begin fails++; $display("FAIL stream_pc c%0d got %h want %h", k, out_pc, 8'(k - 2)); end
            tests++; if (out_instr !== 32'(k - 2) + 32'h100) begin fails++; $display("FAIL stream_instr c%0d got %h want %h", k, out_instr, 32'(k - 2) + 32'h100); end
         end
      end
   endtask

   task automatic test_stall;
      restart(1'b0);
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 9) out_ready = 1'b1;
         if (c > 0) #1;
         if (c < 10) begin
            tests++; if (imem_en !== (c < 4)) begin fails++; $display("FAIL stall_en c%0d got %b want %b", c, imem_en, (c < 4)); end
         end
         if (c < 4) begin
            tests++; if (imem_addr !== 8'(c)) begin fails++; $display("FAIL stall_addr c%0d got %h want %h", c, imem_addr, 8'(c)); end
         end
         tests++; if (out_valid !== (c >= 2)) begin fails++; $display("FAIL stall_valid c%0d got %b want %b", c, out_valid, (c >= 2)); end
         if (c >= 2 && c < 9) begin
            tests++; if (out_pc !== 8'h00) begin fails++; $display("FAIL stall_hold c%0d got %h want 00", c, out_pc); end
         end
         if (c >= 9) begin
            tests++; if (out_pc !== 8'(c - 9)) begin fails++; $display("FAIL stall_drain c%0d got %h want %h", c, out_pc, 8'(c - 9)); end
            tests++; if (out_instr !== 32'(c - 9) + 32'h100) begin fails++; $display("FAIL stall_instr c%0d got %h want %h", c, out_instr, 32'(c - 9) + 32'h100); end
         end
      end
   endtask

   task automatic test_redirect;
      restart(1'b0);
      for (int c = 1; c < 4; c++) begin @(negedge clk); #1; end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 8'h40;
      #1;
      tests++; if (imem_en !== 1'b0) begin fails++; $display("FAIL redir_en_c4 got %b want 0", imem_en); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL redir_pre_valid got %b want 1", out_valid); end
      @(negedge clk);
      redirect_valid = 1'b0; out_ready = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_valid_c5 got %b want 0", out_valid); end
      tests++; if (imem_addr !== 8'h40 || imem_en !== 1'b1) begin fails++; $display("FAIL redir_issue_c5 got en=%b addr=%h want en=1 addr=40", imem_en, imem_addr); end
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_valid_c6 got %b want 0", out_valid); end
      tests++; if (imem_addr !== 8'h41) begin fails++; $display("FAIL redir_addr_c6 got %h want 41", imem_addr); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         tests++; if (out_valid !== 1'b1 || out_pc !== 8'h40 + 8'(k)) begin fails++; $display("FAIL redir_out k%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 8'h40 + 8'(k)); end
         tests++; if (out_instr !== 32'h140 + 32'(k)) begin fails++; $display("FAIL redir_instr k%0d got %h want %h", k, out_instr, 32'h140 + 32'(k)); end
      end
   endtask

   task automatic test_wrap;
      logic [7:0] exp_pc;
      restart(1'b1);
      for (int c = 1; c < 3; c++) begin @(negedge clk); #1; end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 8'hFE;
      #1;
      tests++; if (imem_en !== 1'b0) begin fails++; $display("FAIL wrap_en_redir got %b want 0", imem_en); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || imem_addr !== 8'hFE) begin fails++; $display("FAIL wrap_c4 got v=%b addr=%h want v=0 addr=fe", out_valid, imem_addr); end
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b0 || imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_c5 got v=%b addr=%h want v=0 addr=ff", out_valid, imem_addr); end
      exp_pc = 8'hFE;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         tests++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin fails++; $display("FAIL wrap_out k%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, exp_pc); end
         tests++; if (out_instr !== 32'h100 + 32'(exp_pc)) begin fails++; $display("FAIL wrap_instr k%0d got %h want %h", k, out_instr, 32'h100 + 32'(exp_pc)); end
         exp_pc = exp_pc + 8'h01;
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_pc;
      restart(1'b0);
      for (int c = 1; c < 5; c++) begin @(negedge clk); #1; end
      exp_pc = 8'h00;
      for (int c = 5; c < 29; c++) begin
         @(negedge clk);
         out_ready = (c % 2 == 1);
         #1;
         tests++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin fails++; $display("FAIL b2b_head c%0d got v=%b pc=%h want v=1 pc=%h", c, out_valid, out_pc, exp_pc); end
         tests++; if (out_instr !== 32'h100 + 32'(exp_pc)) begin fails++; $display("FAIL b2b_instr c%0d got %h want %h", c, out_instr, 32'h100 + 32'(exp_pc)); end
         if (out_ready) exp_pc = exp_pc + 8'h01;
      end
   endtask

   task automatic test_async_reset;
      restart(1'b1);
      for (int c = 1; c < 5; c++) begin @(negedge clk); #1; end
      #2;
      reset = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid got %b want 0", out_valid); end
      tests++; if (imem_en !== 1'b0) begin fails++; $display("FAIL areset_en got %b want 0", imem_en); end
      tests++; if (imem_addr !== 8'h00 || out_pc !== 8'h00) begin fails++; $display("FAIL areset_state got addr=%h pc=%h want 00 00", imem_addr, out_pc); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++; if (imem_en !== 1'b1 || imem_addr !== 8'h00) begin fails++; $display("FAIL arestart_issue got en=%b addr=%h want en=1 addr=00", imem_en, imem_addr); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arestart_valid got %b want 0", out_valid); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 32'h100) begin fails++; $display("FAIL arestart_out got v=%b pc=%h instr=%h want v=1 pc=00 instr=100", out_valid, out_pc, out_instr); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
